vlc_tx_scheduler: RTL and testbench
===================================

Name: vlc_tx_scheduler

Overview:
- Frame-level controller for the VLC transmit path.
- Queues transmit descriptors (DDR start address + length in words) from the host/CPU side.
- Launches the read master / serializer chain one frame at a time and waits for its done indication.
- Enforces a programmable inter-frame gap so the optical receiver can resynchronise between frames. Runs in the 50 MHz system clock domain.

Parameters:
- DEPTH, 4: descriptor queue depth in entries; power of 2, >= 2.
- ADDR_W, 32: descriptor address width.
- LEN_W, 32: descriptor length width, in 32-bit words.
- GAP_CYCLES, 1000: idle iClk cycles inserted after each frame's done; 0 = no gap.
- TIMEOUT_CYCLES, 16777216: watchdog limit in WAIT_DONE; used only with the optional feature.

Ports:
- iClk  in  1  system clock, 50 MHz.
- iReset  in  1  synchronous, active-high reset.
- iDesc_valid  in  1  descriptor push request.
- iDesc_addr  in  ADDR_W  frame start address.
- iDesc_len  in  LEN_W  frame length in words.
- oDesc_ready  out  1  queue not full; a push occurs when iDesc_valid & oDesc_ready.
- iEnable  in  1  when high, the scheduler may launch new frames.
- iTx_done  in  1  done from the read master; level or pulse.
- oTx_start  out  1  single-cycle start pulse to the read master.
- oTx_addr  out  ADDR_W  start address for the read master; held stable from start until done.
- oTx_len  out  LEN_W  length for the read master; held stable from start until done.
- oBusy  out  1  high in any state other than IDLE.
- oFrame_cnt  out  16  number of completed frames; wraps.
- oQueue_level  out  clog2(DEPTH)+1  number of queued descriptors.
- oTimeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (synchronous, iReset=1 at a posedge):
  - Queue flushed; state goes to IDLE.
  - oTx_start=0, oTx_addr=0, oTx_len=0, oBusy=0, oFrame_cnt=0, oQueue_level=0, oTimeout=0, oDesc_ready=1.
  - Reset asserted mid-frame aborts the frame immediately; there is no handshake with the read master.
- Queue:
  - Circular buffer of {addr,len} entries.
  - Push when iDesc_valid & oDesc_ready; oDesc_ready = (level != DEPTH).
  - A push while full is ignored; no overwrite.
  - A pop occurs only in IDLE→LOAD.
  - Push and pop in the same cycle leaves the level unchanged.
  - A descriptor pushed into an empty queue is poppable on the next cycle.
- Done detection: registered edge detector, done_rise = iTx_done & ~iTx_done_q. Edges are honoured only in WAIT_DONE and ignored in all other states.
- FSM:
  - IDLE: if level != 0 and iEnable=1, pop the head → LOAD.
  - LOAD:
    - Register the popped addr/len into oTx_addr/oTx_len.
    - If len == 0, discard the descriptor (no start, no count) → IDLE.
    - Otherwise → START.
  - START: oTx_start=1 for exactly this one cycle → WAIT_DONE.
  - WAIT_DONE: on done_rise, increment oFrame_cnt (0xFFFF wraps to 0) → GAP.
  - GAP:
    - Down-counter loaded with GAP_CYCLES on entry.
    - → IDLE when the counter reaches 0, giving exactly GAP_CYCLES cycles in GAP.
    - If GAP_CYCLES=0, WAIT_DONE goes directly to IDLE.
- Launch latency: a queued descriptor in IDLE with iEnable=1 produces oTx_start two cycles later (IDLE→LOAD→START).
- iEnable deassertion:
  - Does not abort an in-flight frame; the frame completes, including its GAP.
  - The scheduler then holds in IDLE with the queue preserved.
- Back-to-back frames: the minimum spacing from done_rise to the next oTx_start is GAP_CYCLES + 3 cycles.
- oTx_addr/oTx_len keep their last values after done and update only in LOAD.

Optional Feature:
- Macro: VLC_TX_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT_DONE and counts each cycle there.
  - If it reaches TIMEOUT_CYCLES without done_rise, oTimeout is set and sticks until iReset.
  - The FSM then goes to GAP with oFrame_cnt not incremented.
  - If done_rise and the timeout occur in the same cycle, done wins.
- Not defined: no counter logic; oTimeout is tied to 0.

Test Plan:
- Reset, then push {0x1000,64} with iEnable=1 → oTx_start pulses for 1 cycle 2 cycles after the pop; oTx_addr=0x1000, oTx_len=64. Pulse iTx_done → oFrame_cnt=1. With GAP_CYCLES=10, oBusy drops exactly 11 cycles after done_rise.
- iEnable=0, push 5 descriptors into DEPTH=4 → the 5th is dropped; oDesc_ready=0; oQueue_level=4. Set iEnable=1 → exactly 4 starts, in FIFO order.
- Push {0x2000,0} then {0x3000,8} → no start for the zero-length entry; one start with addr 0x3000; oFrame_cnt=1.
- Hold iTx_done high through START, then keep it level-high for 100 cycles in WAIT_DONE → no false completion until a new rising edge; exactly one count per edge.
- Assert iReset for 1 cycle while in WAIT_DONE with 2 entries queued → next cycle: state IDLE, oQueue_level=0, oFrame_cnt=0, oBusy=0.
- VLC_TX_TIMEOUT_EN defined, TIMEOUT_CYCLES=50, no done → oTimeout=1 50 cycles after WAIT_DONE entry; oFrame_cnt unchanged; next queued frame launches after the gap.

Source files
------------

// File: rtl/vlc_tx_scheduler.sv
// VLC transmit frame scheduler: descriptor FIFO, one-frame-at-a-time launch, inter-frame gap.
// Optional watchdog on the read-master done handshake is enabled by defining VLC_TX_TIMEOUT_EN.
module vlc_tx_scheduler #(
  parameter int DEPTH          = 4,
  parameter int ADDR_W         = 32,
  parameter int LEN_W          = 32,
  parameter int GAP_CYCLES     = 1000,
  parameter int TIMEOUT_CYCLES = 16777216
) (
  input  logic                     iClk,
  input  logic                     iReset,
  input  logic                     iDesc_valid,
  input  logic [ADDR_W-1:0]        iDesc_addr,
  input  logic [LEN_W-1:0]         iDesc_len,
  output logic                     oDesc_ready,
  input  logic                     iEnable,
  input  logic                     iTx_done,
  output logic                     oTx_start,
  output logic [ADDR_W-1:0]        oTx_addr,
  output logic [LEN_W-1:0]         oTx_len,
  output logic                     oBusy,
  output logic [15:0]              oFrame_cnt,
  output logic [$clog2(DEPTH):0]   oQueue_level,
  output logic                     oTimeout
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [LEN_W-1:0]  len_mem  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [ADDR_W-1:0] head_addr;
  logic [LEN_W-1:0]  head_len;
  logic [GAP_W-1:0]  gap_cnt;
  logic              done_q;
  logic              done_rise;
  logic              push;
  logic              pop;
  logic              wd_expired;

  assign oDesc_ready  = (level != LVL_W'(DEPTH));
  assign oQueue_level = level;
  assign oBusy        = (state != S_IDLE);
  assign oTx_start    = (state == S_START);
  assign push         = iDesc_valid & oDesc_ready;
  assign pop          = (state == S_IDLE) && (level != '0) && iEnable;
  assign done_rise    = iTx_done & ~done_q;

  // Queue storage is not reset; validity is tracked entirely by the pointers and level.
  always_ff @(posedge iClk) begin
    if (push) begin
      addr_mem[wr_ptr] <= iDesc_addr;
      len_mem[wr_ptr]  <= iDesc_len;
    end
  end

`ifdef VLC_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog restarts on every launch; a coincident done edge takes priority over expiry.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      wd_cnt   <= '0;
      oTimeout <= 1'b0;
    end else if (state == S_START) begin
      wd_cnt <= '0;
    end else if (state == S_WAIT) begin
      wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_expired && !done_rise)
        oTimeout <= 1'b1;
    end
  end
`else
  assign wd_expired = 1'b0;
  assign oTimeout   = 1'b0;
`endif

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      head_addr  <= '0;
      head_len   <= '0;
      oTx_addr   <= '0;
      oTx_len    <= '0;
      oFrame_cnt <= '0;
      gap_cnt    <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= iTx_done;
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase

      case (state)
        S_IDLE: begin
          if (pop) begin
            head_addr <= addr_mem[rd_ptr];
            head_len  <= len_mem[rd_ptr];
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          oTx_addr <= head_addr;
          oTx_len  <= head_len;
          // Zero-length descriptors are dropped without ever reaching the read master.
          state    <= (head_len == '0) ? S_IDLE : S_START;
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (done_rise || wd_expired) begin
            if (done_rise)
              oFrame_cnt <= oFrame_cnt + 16'd1;
            if (GAP_CYCLES == 0) begin
              state <= S_IDLE;
            end else begin
              state   <= S_GAP;
              gap_cnt <= GAP_W'(GAP_CYCLES - 1);
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == '0)
            state <= S_IDLE;
          else
            gap_cnt <= gap_cnt - GAP_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vlc_tx_scheduler.sv
// Directed bench for vlc_tx_scheduler: a scoreboard of expected launches is checked on every start pulse.
// The watchdog section is compiled only when VLC_TX_TIMEOUT_EN is defined.
module tb_vlc_tx_scheduler;

  localparam int DEPTH   = 4;
  localparam int GAP     = 10;
  localparam int TIMEOUT = 50;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] len;
  } desc_t;

  logic        iClk = 1'b0;
  logic        iReset = 1'b1;
  logic        iDesc_valid = 1'b0;
  logic [31:0] iDesc_addr = '0;
  logic [31:0] iDesc_len = '0;
  logic        oDesc_ready;
  logic        iEnable = 1'b0;
  logic        iTx_done = 1'b0;
  logic        oTx_start;
  logic [31:0] oTx_addr;
  logic [31:0] oTx_len;
  logic        oBusy;
  logic [15:0] oFrame_cnt;
  logic [2:0]  oQueue_level;
  logic        oTimeout;

  int    assert_cnt = 0;
  int    fail_cnt = 0;
  int    exp_frames = 0;
  desc_t exp_q[$];

  vlc_tx_scheduler #(
    .DEPTH(DEPTH), .ADDR_W(32), .LEN_W(32),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .iClk(iClk), .iReset(iReset),
    .iDesc_valid(iDesc_valid), .iDesc_addr(iDesc_addr), .iDesc_len(iDesc_len),
    .oDesc_ready(oDesc_ready), .iEnable(iEnable), .iTx_done(iTx_done),
    .oTx_start(oTx_start), .oTx_addr(oTx_addr), .oTx_len(oTx_len),
    .oBusy(oBusy), .oFrame_cnt(oFrame_cnt), .oQueue_level(oQueue_level),
    .oTimeout(oTimeout)
  );

  always #10 iClk = ~iClk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] global timeout");
  end

  // All sampling and driving happens on the falling edge, away from the active edge.
  task automatic tick();
    @(negedge iClk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_desc(input logic [31:0] addr, input logic [31:0] len,
                           input bit accept, input bit launch);
    desc_t d;
    iDesc_valid = 1'b1;
    iDesc_addr  = addr;
    iDesc_len   = len;
    check("desc_ready", {63'd0, oDesc_ready}, {63'd0, accept});
    if (accept && launch && len != 0) begin
      d.addr = addr;
      d.len  = len;
      exp_q.push_back(d);
    end
    tick();
    iDesc_valid = 1'b0;
  endtask

  task automatic wait_start(input int max_cycles, output int n);
    desc_t d;
    n = 0;
    do begin
      tick();
      n++;
    end while (!oTx_start && n < max_cycles);
    check("start_seen", {63'd0, oTx_start}, 64'd1);
    if (oTx_start) begin
      if (exp_q.size() == 0) begin
        check("unexpected_start", {63'd0, oTx_start}, 64'd0);
      end else begin
        d = exp_q.pop_front();
        check("tx_addr", {32'd0, oTx_addr}, {32'd0, d.addr});
        check("tx_len", {32'd0, oTx_len}, {32'd0, d.len});
      end
      tick();
      check("start_width", {63'd0, oTx_start}, 64'd0);
    end
  endtask

  task automatic done_pulse();
    iTx_done = 1'b1;
    tick();
    iTx_done = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (oBusy && n < max_cycles) begin
      tick();
      n++;
    end
    check("idle_reached", {63'd0, oBusy}, 64'd0);
  endtask

  initial begin
    int n;

    // Reset state.
    tick();
    tick();
    iReset = 1'b0;
    check("rst_busy", {63'd0, oBusy}, 64'd0);
    check("rst_start", {63'd0, oTx_start}, 64'd0);
    check("rst_addr", {32'd0, oTx_addr}, 64'd0);
    check("rst_len", {32'd0, oTx_len}, 64'd0);
    check("rst_frames", {48'd0, oFrame_cnt}, 64'd0);
    check("rst_level", {61'd0, oQueue_level}, 64'd0);
    check("rst_ready", {63'd0, oDesc_ready}, 64'd1);
    check("rst_timeout", {63'd0, oTimeout}, 64'd0);

    // Single frame: latency, done count, gap length.
    $display("[TB] single frame");
    iEnable = 1'b1;
    push_desc(32'h1000, 32'd64, 1'b1, 1'b1);
    check("t1_level", {61'd0, oQueue_level}, 64'd1);
    wait_start(10, n);
    check("t1_latency", 64'(n), 64'd2);
    done_pulse();
    exp_frames++;
    check("t1_frames", {48'd0, oFrame_cnt}, 64'(exp_frames));
    repeat (GAP - 1) tick();
    check("t1_busy_in_gap", {63'd0, oBusy}, 64'd1);
    tick();
    check("t1_busy_after_gap", {63'd0, oBusy}, 64'd0);
    check("t1_addr_held", {32'd0, oTx_addr}, 64'h1000);

    // Overfill while disabled, then drain in FIFO order back to back.
    $display("[TB] queue overflow and FIFO order");
    iEnable = 1'b0;
    for (int i = 0; i < 5; i++)
      push_desc(32'hA000 + 32'(i * 16), 32'(i + 1), i < DEPTH, 1'b1);
    check("t2_level_full", {61'd0, oQueue_level}, 64'(DEPTH));
    check("t2_ready_full", {63'd0, oDesc_ready}, 64'd0);
    repeat (3) tick();
    check("t2_hold_idle", {63'd0, oBusy}, 64'd0);
    check("t2_hold_level", {61'd0, oQueue_level}, 64'(DEPTH));
    iEnable = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wait_start(40, n);
      check(i == 0 ? "t2_first_latency" : "t2_spacing", 64'(n), i == 0 ? 64'd2 : 64'(GAP + 2));
      done_pulse();
      exp_frames++;
      check("t2_frames", {48'd0, oFrame_cnt}, 64'(exp_frames));
    end
    wait_idle(40);
    check("t2_level_empty", {61'd0, oQueue_level}, 64'd0);
    check("t2_ready_empty", {63'd0, oDesc_ready}, 64'd1);

    // Zero-length descriptor is discarded.
    $display("[TB] zero-length discard");
    push_desc(32'h2000, 32'd0, 1'b1, 1'b1);
    push_desc(32'h3000, 32'd8, 1'b1, 1'b1);
    wait_start(20, n);
    done_pulse();
    exp_frames++;
    check("t3_frames", {48'd0, oFrame_cnt}, 64'(exp_frames));
    wait_idle(40);
    check("t3_addr_held", {32'd0, oTx_addr}, 64'h3000);
    check("t3_len_held", {32'd0, oTx_len}, 64'd8);

    // Done held high before launch must not complete the frame.
    $display("[TB] level-high done");
    iTx_done = 1'b1;
    push_desc(32'h4000, 32'd16, 1'b1, 1'b1);
    wait_start(20, n);
    repeat (100) tick();
    check("t4_no_false_done", {48'd0, oFrame_cnt}, 64'(exp_frames));
    check("t4_still_busy", {63'd0, oBusy}, 64'd1);
    iTx_done = 1'b0;
    tick();
    check("t4_fall_no_count", {48'd0, oFrame_cnt}, 64'(exp_frames));
    iTx_done = 1'b1;
    tick();
    exp_frames++;
    check("t4_edge_count", {48'd0, oFrame_cnt}, 64'(exp_frames));
    repeat (5) tick();
    check("t4_one_per_edge", {48'd0, oFrame_cnt}, 64'(exp_frames));
    iTx_done = 1'b0;
    wait_idle(40);
`ifndef VLC_TX_TIMEOUT_EN
    check("t4_timeout_tied", {63'd0, oTimeout}, 64'd0);
`endif

    // Reset mid-frame flushes everything.
    $display("[TB] reset during WAIT_DONE");
    push_desc(32'h5000, 32'd4, 1'b1, 1'b1);
    wait_start(20, n);
    push_desc(32'h6000, 32'd1, 1'b1, 1'b0);
    push_desc(32'h7000, 32'd2, 1'b1, 1'b0);
    check("t5_level_pre", {61'd0, oQueue_level}, 64'd2);
    iReset = 1'b1;
    tick();
    iReset = 1'b0;
    exp_frames = 0;
    check("t5_busy", {63'd0, oBusy}, 64'd0);
    check("t5_level", {61'd0, oQueue_level}, 64'd0);
    check("t5_frames", {48'd0, oFrame_cnt}, 64'd0);
    check("t5_addr", {32'd0, oTx_addr}, 64'd0);
    check("t5_ready", {63'd0, oDesc_ready}, 64'd1);
    done_pulse();
    check("t5_done_ignored", {48'd0, oFrame_cnt}, 64'd0);

`ifdef VLC_TX_TIMEOUT_EN
    $display("[TB] watchdog timeout");
    push_desc(32'h8000, 32'd3, 1'b1, 1'b1);
    push_desc(32'h9000, 32'd5, 1'b1, 1'b1);
    wait_start(20, n);
    repeat (TIMEOUT - 1) tick();
    check("t6_timeout_early", {63'd0, oTimeout}, 64'd0);
    tick();
    check("t6_timeout_set", {63'd0, oTimeout}, 64'd1);
    check("t6_frames", {48'd0, oFrame_cnt}, 64'(exp_frames));
    wait_start(40, n);
    check("t6_relaunch", 64'(n), 64'(GAP + 2));
    done_pulse();
    exp_frames++;
    check("t6_frames_after", {48'd0, oFrame_cnt}, 64'(exp_frames));
    check("t6_timeout_sticky", {63'd0, oTimeout}, 64'd1);
    wait_idle(40);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
